// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between the pin operand path (id 0)
// and the serial command path (id 1). Sequences start/done, enforces a
// completion timeout and returns a tagged result with backpressure.
module alu_rr_arbiter #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Last WAIT cycle index before the timeout fires, and the saturation ceiling.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       gnt0;
    logic       gnt1;

    // Grant decision: a lone requester wins, a tie goes to the one not served last.
    // Gated by rst_n so no ready is seen while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && ena && rst_n) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Next-state logic; done takes priority over an expiring counter.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt0 || gnt1) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (alu_done || wait_cnt == CNT_LAST) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, timeout counting, result latching and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            wait_cnt   <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        alu_a  <= gnt1 ? req1_a  : req0_a;
                        alu_b  <= gnt1 ? req1_b  : req0_b;
                        alu_op <= gnt1 ? req1_op : req0_op;
                        rsp_id <= gnt1;
                    end
                end
                ISSUE: wait_cnt <= 8'd0;
                WAIT: begin
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end else if (wait_cnt < CNT_MAX) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: if (rsp_ready) last_grant <= rsp_id;
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_start  = (state == ISSUE);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

endmodule
